pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Takes the decode-stage control word from the control unit and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and control hazards and issues stall and flush signals to the datapath.
- Drives the EX-stage forwarding mux selects.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- ALU_CTRL_W, 3, ALU control word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_wr_d, mem2reg_d, mem_wr_d, branch_d, alu_src_d, reg_dst_d, jmp_d  in  1 each  decode-stage control bits.
- alu_control_d  in  ALU_CTRL_W  decode-stage ALU control word.
- rs_d, rt_d, rd_d  in  REG_ADDR_W  decode-stage register fields.
- zero_e  in  1  ALU zero flag from EX.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID register.
- flush_d  out  1  clear IF/ID register (insert NOP).
- jmp_take_d  out  1  redirect PC to jump target.
- pc_src_e  out  1  redirect PC to branch target.
- reg_wr_e, mem2reg_e, mem_wr_e, branch_e, alu_src_e, reg_dst_e  out  1 each  ID/EX control bits.
- alu_control_e  out  ALU_CTRL_W  ID/EX ALU control word.
- rs_e, rt_e, rd_e  out  REG_ADDR_W  ID/EX register fields.
- forward_a_e, forward_b_e  out  2  EX operand select: 00 = regfile, 10 = EX/MEM ALU result, 01 = MEM/WB result.
- reg_wr_m, mem2reg_m, mem_wr_m  out  1 each  EX/MEM control bits.
- write_reg_m  out  REG_ADDR_W  EX/MEM destination register.
- reg_wr_w, mem2reg_w  out  1 each  MEM/WB control bits.
- write_reg_w  out  REG_ADDR_W  MEM/WB destination register.

Behaviour:
- Reset (async, active-high): every stage register clears to 0, i.e. all stages are bubbles. Consequently stall_f, stall_d, flush_d, pc_src_e, jmp_take_d, and both forward selects read 0 while rst is high.
- write_reg_e (internal) = reg_dst_e ? rd_e : rt_e.
- Combinational hazard outputs:
  - lw_stall = mem2reg_e & (rt_e != 0) & ((rt_e == rs_d) | (rt_e == rt_d)).
  - pc_src_e = branch_e & zero_e.
  - stall_f = stall_d = lw_stall.
  - jmp_take_d = jmp_d & ~lw_stall.
  - flush_d = pc_src_e | jmp_take_d.
- Forwarding for A (B identical, with rt_e in place of rs_e):
  - 10 if reg_wr_m & (write_reg_m != 0) & (write_reg_m == rs_e).
  - else 01 if reg_wr_w & (write_reg_w != 0) & (write_reg_w == rs_e).
  - else 00.
  - MEM beats WB when both match (newest value wins). Register 0 is never forwarded.
- ID/EX update each clk:
  - Bubble (all control bits and register fields 0) if lw_stall | pc_src_e.
  - Otherwise load the *_d inputs.
  - A stall bubbles E only; D and F hold.
- EX/MEM and MEM/WB update every clk unconditionally; these are never stalled or flushed.
  - EX/MEM loads reg_wr_e, mem2reg_e, mem_wr_e, write_reg_e.
  - MEM/WB loads reg_wr_m, mem2reg_m, write_reg_m.
- Latency: a control word presented at D appears at E after 1 clk, M after 2, W after 3.
- Load-use stall is exactly 1 cycle: after the bubble, the load is in M and mem2reg_e = 0.
- Simultaneous events:
  - lw_stall and pc_src_e are mutually exclusive, since E holds either a load or a branch.
  - A taken branch in E with a jump in D: both flush_d and pc_src_e are 1. The datapath gives pc_src_e priority for PC selection. The jump in D is squashed by the ID/EX bubble.
  - A jump in D during lw_stall is deferred: jmp_take_d = 0 and flush_d = 0 while the stall holds, then it proceeds the next cycle.
- Reset asserted mid-stall or mid-flush clears all in-flight control immediately, with no partial state retained.

Test Plan:
- Reset: assert rst mid-stream with reg_wr_d=1 -> all outputs 0 the same cycle, including reg_wr_e/m/w=0 and forward selects 00.
- ALU forward: D0 = add r3 (reg_wr=1, reg_dst=1, rd=3), next D1 with rs=3, rt=3 -> when D1 is in E, forward_a_e=10 and forward_b_e=10. Inserting one independent instruction between them -> 01/01 instead.
- Load-use: lw to rt=5 (mem2reg=1, reg_dst=0), then instruction with rs=5 -> stall_f = stall_d = 1 for exactly 1 cycle, E bubble (reg_wr_e=0 next clk), then forward_a_e=01. Same sequence with rt=0 -> no stall.
- Branch taken: branch_d=1 entered, then zero_e=1 while it is in E -> pc_src_e=1, flush_d=1, ID/EX bubbled next clk. With zero_e=0 -> pc_src_e=0 and no flush.
- Jump during stall: load-use stall active with jmp_d=1 -> jmp_take_d=0 and flush_d=0. Next cycle jmp_take_d=1, flush_d=1.
- Double forward: MEM and WB both write r7, E reads rs=7 -> forward_a_e=10. A write to r0 from either stage -> 00.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline control registers, hazard detection and forwarding selects
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_wr_d,
  input  logic                  mem2reg_d,
  input  logic                  mem_wr_d,
  input  logic                  branch_d,
  input  logic                  alu_src_d,
  input  logic                  reg_dst_d,
  input  logic                  jmp_d,
  input  logic [ALU_CTRL_W-1:0] alu_control_d,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  zero_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  jmp_take_d,
  output logic                  pc_src_e,
  output logic                  reg_wr_e,
  output logic                  mem2reg_e,
  output logic                  mem_wr_e,
  output logic                  branch_e,
  output logic                  alu_src_e,
  output logic                  reg_dst_e,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic [REG_ADDR_W-1:0] rs_e,
  output logic [REG_ADDR_W-1:0] rt_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  reg_wr_m,
  output logic                  mem2reg_m,
  output logic                  mem_wr_m,
  output logic [REG_ADDR_W-1:0] write_reg_m,
  output logic                  reg_wr_w,
  output logic                  mem2reg_w,
  output logic [REG_ADDR_W-1:0] write_reg_w
);

  typedef struct packed {
    logic                  reg_wr;
    logic                  mem2reg;
    logic                  mem_wr;
    logic                  branch;
    logic                  alu_src;
    logic                  reg_dst;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                  reg_wr;
    logic                  mem2reg;
    logic                  mem_wr;
    logic [REG_ADDR_W-1:0] write_reg;
  } ex_mem_t;

  typedef struct packed {
    logic                  reg_wr;
    logic                  mem2reg;
    logic [REG_ADDR_W-1:0] write_reg;
  } mem_wb_t;

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic                  lw_stall;
  logic [REG_ADDR_W-1:0] write_reg_e;

  assign write_reg_e = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;

  // Hazard detection: load-use stall, taken branch redirect, jump redirect (held off while stalled or in reset)
  always_comb begin
    lw_stall   = id_ex_q.mem2reg && (id_ex_q.rt != '0) &&
                 ((id_ex_q.rt == rs_d) || (id_ex_q.rt == rt_d));
    pc_src_e   = id_ex_q.branch & zero_e;
    jmp_take_d = jmp_d & ~lw_stall & ~rst;
    flush_d    = pc_src_e | jmp_take_d;
    stall_f    = lw_stall;
    stall_d    = lw_stall;
  end

  // Forwarding selects: the MEM-stage result is newer than WB, so it is checked first; r0 is never forwarded
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (ex_mem_q.reg_wr && (ex_mem_q.write_reg != '0) && (ex_mem_q.write_reg == id_ex_q.rs))
      forward_a_e = 2'b10;
    else if (mem_wb_q.reg_wr && (mem_wb_q.write_reg != '0) && (mem_wb_q.write_reg == id_ex_q.rs))
      forward_a_e = 2'b01;
    if (ex_mem_q.reg_wr && (ex_mem_q.write_reg != '0) && (ex_mem_q.write_reg == id_ex_q.rt))
      forward_b_e = 2'b10;
    else if (mem_wb_q.reg_wr && (mem_wb_q.write_reg != '0) && (mem_wb_q.write_reg == id_ex_q.rt))
      forward_b_e = 2'b01;
  end

  // Next-state for the stage registers: ID/EX takes a bubble on a load-use stall or a taken branch
  always_comb begin
    id_ex_d = '0;
    if (!(lw_stall || pc_src_e)) begin
      id_ex_d.reg_wr      = reg_wr_d;
      id_ex_d.mem2reg     = mem2reg_d;
      id_ex_d.mem_wr      = mem_wr_d;
      id_ex_d.branch      = branch_d;
      id_ex_d.alu_src     = alu_src_d;
      id_ex_d.reg_dst     = reg_dst_d;
      id_ex_d.alu_control = alu_control_d;
      id_ex_d.rs          = rs_d;
      id_ex_d.rt          = rt_d;
      id_ex_d.rd          = rd_d;
    end
    ex_mem_d.reg_wr    = id_ex_q.reg_wr;
    ex_mem_d.mem2reg   = id_ex_q.mem2reg;
    ex_mem_d.mem_wr    = id_ex_q.mem_wr;
    ex_mem_d.write_reg = write_reg_e;
    mem_wb_d.reg_wr    = ex_mem_q.reg_wr;
    mem_wb_d.mem2reg   = ex_mem_q.mem2reg;
    mem_wb_d.write_reg = ex_mem_q.write_reg;
  end

  // Stage registers: reset empties the whole pipeline into bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign reg_wr_e      = id_ex_q.reg_wr;
  assign mem2reg_e     = id_ex_q.mem2reg;
  assign mem_wr_e      = id_ex_q.mem_wr;
  assign branch_e      = id_ex_q.branch;
  assign alu_src_e     = id_ex_q.alu_src;
  assign reg_dst_e     = id_ex_q.reg_dst;
  assign alu_control_e = id_ex_q.alu_control;
  assign rs_e          = id_ex_q.rs;
  assign rt_e          = id_ex_q.rt;
  assign rd_e          = id_ex_q.rd;
  assign reg_wr_m      = ex_mem_q.reg_wr;
  assign mem2reg_m     = ex_mem_q.mem2reg;
  assign mem_wr_m      = ex_mem_q.mem_wr;
  assign write_reg_m   = ex_mem_q.write_reg;
  assign reg_wr_w      = mem_wb_q.reg_wr;
  assign mem2reg_w     = mem_wb_q.mem2reg;
  assign write_reg_w   = mem_wb_q.write_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed table, reset sequences and randomized model check for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       reg_wr;
    logic       mem2reg;
    logic       mem_wr;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic       jmp;
    logic [2:0] alu;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    instr_t     i;
    logic [4:0] dest;
  } stage_t;

  typedef struct {
    instr_t     d;
    logic       zero;
    logic [4:0] flags;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       reg_wr_d, mem2reg_d, mem_wr_d, branch_d, alu_src_d, reg_dst_d, jmp_d;
  logic [2:0] alu_control_d;
  logic [4:0] rs_d, rt_d, rd_d;
  logic       zero_e;
  logic       stall_f, stall_d, flush_d, jmp_take_d, pc_src_e;
  logic       reg_wr_e, mem2reg_e, mem_wr_e, branch_e, alu_src_e, reg_dst_e;
  logic [2:0] alu_control_e;
  logic [4:0] rs_e, rt_e, rd_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       reg_wr_m, mem2reg_m, mem_wr_m;
  logic [4:0] write_reg_m;
  logic       reg_wr_w, mem2reg_w;
  logic [4:0] write_reg_w;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t   tbl[$];
  stage_t me, mm, mw;

  logic [47:0] dut_vec;
  assign dut_vec = {stall_f, stall_d, flush_d, jmp_take_d, pc_src_e,
                    reg_wr_e, mem2reg_e, mem_wr_e, branch_e, alu_src_e, reg_dst_e,
                    alu_control_e, rs_e, rt_e, rd_e, forward_a_e, forward_b_e,
                    reg_wr_m, mem2reg_m, mem_wr_m, write_reg_m,
                    reg_wr_w, mem2reg_w, write_reg_w};

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .ALU_CTRL_W(3)) dut (
    .clk(clk), .rst(rst),
    .reg_wr_d(reg_wr_d), .mem2reg_d(mem2reg_d), .mem_wr_d(mem_wr_d), .branch_d(branch_d),
    .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .jmp_d(jmp_d), .alu_control_d(alu_control_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .zero_e(zero_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .jmp_take_d(jmp_take_d),
    .pc_src_e(pc_src_e), .reg_wr_e(reg_wr_e), .mem2reg_e(mem2reg_e), .mem_wr_e(mem_wr_e),
    .branch_e(branch_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
    .alu_control_e(alu_control_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .reg_wr_m(reg_wr_m), .mem2reg_m(mem2reg_m), .mem_wr_m(mem_wr_m), .write_reg_m(write_reg_m),
    .reg_wr_w(reg_wr_w), .mem2reg_w(mem2reg_w), .write_reg_w(write_reg_w)
  );

  always #5 clk = ~clk;

  // flags order: reg_wr, mem2reg, mem_wr, branch, alu_src, reg_dst, jmp
  function automatic instr_t ins(input logic [6:0] f, input logic [2:0] alu,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    instr_t x;
    {x.reg_wr, x.mem2reg, x.mem_wr, x.branch, x.alu_src, x.reg_dst, x.jmp} = f;
    x.alu = alu; x.rs = rs; x.rt = rt; x.rd = rd;
    return x;
  endfunction

  // flags order: stall, flush_d, jmp_take_d, pc_src_e, reg_wr_e
  function automatic vec_t row(input instr_t d, input logic z, input logic [4:0] fl,
                               input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.d = d; v.zero = z; v.flags = fl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic apply(input instr_t d, input logic z);
    {reg_wr_d, mem2reg_d, mem_wr_d, branch_d, alu_src_d, reg_dst_d, jmp_d} =
      {d.reg_wr, d.mem2reg, d.mem_wr, d.branch, d.alu_src, d.reg_dst, d.jmp};
    alu_control_d = d.alu; rs_d = d.rs; rt_d = d.rt; rd_d = d.rd;
    zero_e = z;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference forwarding: look for the newest producer of src, skipping r0
  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (mm.i.reg_wr && mm.dest == src) return 2'b10;
    if (mw.i.reg_wr && mw.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_lw(input instr_t d);
    return me.i.mem2reg && (me.i.rt != 5'd0) && ((me.i.rt == d.rs) || (me.i.rt == d.rt));
  endfunction

  function automatic logic [47:0] ref_out(input instr_t d, input logic z, input logic r);
    logic lw, pc, jt;
    lw = ref_lw(d);
    pc = me.i.branch && z;
    jt = d.jmp && !lw && !r;
    return {lw, lw, pc | jt, jt, pc,
            me.i.reg_wr, me.i.mem2reg, me.i.mem_wr, me.i.branch, me.i.alu_src, me.i.reg_dst,
            me.i.alu, me.i.rs, me.i.rt, me.i.rd, ref_fwd(me.i.rs), ref_fwd(me.i.rt),
            mm.i.reg_wr, mm.i.mem2reg, mm.i.mem_wr, mm.dest,
            mw.i.reg_wr, mw.i.mem2reg, mw.dest};
  endfunction

  task automatic ref_step(input instr_t d, input logic z);
    logic squash;
    squash = ref_lw(d) || (me.i.branch && z);
    mw = mm;
    mm = me;
    if (squash) me = '0;
    else begin
      me.i = d;
      me.dest = d.reg_dst ? d.rd : d.rt;
    end
  endtask

  initial begin
    instr_t NOP, ADD3, USE3, IND6, LW5, USE5, LW0, USE0, BR, ADD9, JMP5, JMP0, A7, C10, Z1, Z2, d;
    logic z, r;

    NOP  = '0;
    ADD3 = ins(7'b1000010, 3'd2, 5'd1, 5'd2, 5'd3);
    USE3 = ins(7'b1000010, 3'd2, 5'd3, 5'd3, 5'd4);
    IND6 = ins(7'b1000010, 3'd2, 5'd1, 5'd2, 5'd6);
    LW5  = ins(7'b1100100, 3'd2, 5'd1, 5'd5, 5'd0);
    USE5 = ins(7'b1000010, 3'd2, 5'd5, 5'd2, 5'd7);
    LW0  = ins(7'b1100100, 3'd2, 5'd1, 5'd0, 5'd0);
    USE0 = ins(7'b1000010, 3'd2, 5'd0, 5'd0, 5'd8);
    BR   = ins(7'b0001000, 3'd6, 5'd1, 5'd2, 5'd0);
    ADD9 = ins(7'b1000010, 3'd2, 5'd1, 5'd2, 5'd9);
    JMP5 = ins(7'b0000001, 3'd0, 5'd5, 5'd0, 5'd0);
    JMP0 = ins(7'b0000001, 3'd0, 5'd0, 5'd0, 5'd0);
    A7   = ins(7'b1000010, 3'd2, 5'd1, 5'd2, 5'd7);
    C10  = ins(7'b1000010, 3'd2, 5'd7, 5'd0, 5'd10);
    Z1   = ins(7'b1000010, 3'd2, 5'd1, 5'd2, 5'd0);
    Z2   = ins(7'b1000000, 3'd2, 5'd1, 5'd0, 5'd0);

    // ALU forward from MEM
    tbl.push_back(row(ADD3, 0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(USE3, 0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00001, 2'b10, 2'b10));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));
    // forward from WB with one independent instruction between
    tbl.push_back(row(ADD3, 0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(IND6, 0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(USE3, 0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00001, 2'b01, 2'b01));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));
    // load-use: one stall cycle, bubble, then WB forward
    tbl.push_back(row(LW5,  0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(USE5, 0, 5'b10001, 2'b00, 2'b00));
    tbl.push_back(row(USE5, 0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00001, 2'b01, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));
    // load to r0: no stall
    tbl.push_back(row(LW0,  0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(USE0, 0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));
    // branch taken: flush and E bubble
    tbl.push_back(row(BR,   0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(ADD9, 1, 5'b01010, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));
    // branch not taken
    tbl.push_back(row(BR,   0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(ADD9, 0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));
    // jump deferred by load-use stall
    tbl.push_back(row(LW5,  0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(JMP5, 0, 5'b10001, 2'b00, 2'b00));
    tbl.push_back(row(JMP5, 0, 5'b01100, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b01, 2'b00));
    // MEM and WB both write r7: MEM wins
    tbl.push_back(row(A7,   0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(A7,   0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(C10,  0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00001, 2'b10, 2'b00));
    // writes to r0 in MEM and WB are never forwarded
    tbl.push_back(row(Z1,   0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(Z2,   0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00001, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));
    // taken branch in E with jump in D
    tbl.push_back(row(BR,   0, 5'b00000, 2'b00, 2'b00));
    tbl.push_back(row(JMP0, 1, 5'b01110, 2'b00, 2'b00));
    tbl.push_back(row(NOP,  0, 5'b00000, 2'b00, 2'b00));

    rst = 1'b1;
    apply(NOP, 1'b0);
    tick();
    tick();
    @(negedge clk);
    chk("reset_state", dut_vec, 48'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].d, tbl[i].zero);
      @(negedge clk);
      chk($sformatf("row%0d stall_f", i),    stall_f,     tbl[i].flags[4]);
      chk($sformatf("row%0d stall_d", i),    stall_d,     tbl[i].flags[4]);
      chk($sformatf("row%0d flush_d", i),    flush_d,     tbl[i].flags[3]);
      chk($sformatf("row%0d jmp_take_d", i), jmp_take_d,  tbl[i].flags[2]);
      chk($sformatf("row%0d pc_src_e", i),   pc_src_e,    tbl[i].flags[1]);
      chk($sformatf("row%0d reg_wr_e", i),   reg_wr_e,    tbl[i].flags[0]);
      chk($sformatf("row%0d forward_a", i),  forward_a_e, tbl[i].fa);
      chk($sformatf("row%0d forward_b", i),  forward_b_e, tbl[i].fb);
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-stall with a pending jump and a full pipeline
    apply(ADD3, 1'b0); tick();
    apply(ADD3, 1'b0); tick();
    apply(LW5, 1'b0);  tick();
    apply(USE5, 1'b0);
    jmp_d = 1'b1;
    @(negedge clk);
    chk("pre_rst stall_f", stall_f, 1'b1);
    chk("pre_rst reg_wr_m", reg_wr_m, 1'b1);
    chk("pre_rst reg_wr_w", reg_wr_w, 1'b1);
    chk("pre_rst forward_b", forward_b_e, 2'b00);
    rst = 1'b1;
    #1;
    chk("mid_rst all_outputs", dut_vec, 48'h0);
    @(posedge clk);
    #1;
    chk("held_rst all_outputs", dut_vec, 48'h0);
    rst = 1'b0;
    apply(ADD3, 1'b0);
    @(negedge clk);
    chk("post_rst reg_wr_e", reg_wr_e, 1'b0);
    tick();
    @(negedge clk);
    chk("post_rst load reg_wr_e", reg_wr_e, 1'b1);
    chk("post_rst rd_e", rd_e, 5'd3);
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model
    rst = 1'b1;
    me = '0; mm = '0; mw = '0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 49) == 0);
      d.reg_wr  = $urandom_range(0, 1);
      d.mem2reg = ($urandom_range(0, 2) == 0);
      d.mem_wr  = ($urandom_range(0, 3) == 0);
      d.branch  = ($urandom_range(0, 5) == 0);
      d.alu_src = $urandom_range(0, 1);
      d.reg_dst = $urandom_range(0, 1);
      d.jmp     = ($urandom_range(0, 7) == 0);
      d.alu     = 3'($urandom_range(0, 7));
      d.rs      = 5'($urandom_range(0, 3));
      d.rt      = 5'($urandom_range(0, 3));
      d.rd      = 5'($urandom_range(0, 3));
      z         = $urandom_range(0, 1);
      rst = r;
      apply(d, z);
      if (r) begin
        me = '0; mm = '0; mw = '0;
      end
      @(negedge clk);
      chk($sformatf("rand cyc%0d", c), dut_vec, ref_out(d, z, r));
      @(posedge clk);
      #1;
      if (!r) ref_step(d, z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
